// File: rtl/demux_stream_1ton.sv
// demux_stream_1ton
//
// Registered 1-to-NOUT stream demultiplexer with valid/ready handshaking.
// The destination of a packet is taken from in_sel on its first beat and
// stays locked until the last beat transfers. Each output channel has one
// holding register. Beats whose destination is out of range are consumed,
// discarded and counted in a saturating 16-bit counter.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    input beat payload (WIDTH)
//   in_valid   input beat present
//   in_last    final beat of the packet
//   in_sel     destination channel, sampled on the first beat only (SELW)
//   in_ready   beat accepted this cycle
//   out_data   channel k payload at [k*WIDTH +: WIDTH]
//   out_valid  channel k holds a beat (NOUT)
//   out_last   held beat is the last of its packet (NOUT)
//   out_ready  channel k consumer accepts (NOUT)
//   drop_cnt   dropped beat count, saturating at 16'hFFFF
//   busy       a packet is in progress
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | next beat is a first beat; destination comes from in_sel
// PKT    | inside a multi-beat packet; destination locked in cur_sel

module demux_stream_1ton #(
   parameter int WIDTH = 8,
   parameter int NOUT  = 8,
   parameter int SELW  = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   input  logic [SELW-1:0]       in_sel,
   output logic                  in_ready,
   output logic [NOUT*WIDTH-1:0] out_data,
   output logic [NOUT-1:0]       out_valid,
   output logic [NOUT-1:0]       out_last,
   input  logic [NOUT-1:0]       out_ready,
   output logic [15:0]           drop_cnt,
   output logic                  busy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_PKT  = 1'b1;

   logic [0:0]      state;
   logic [SELW-1:0] cur_sel;
   logic [SELW-1:0] eff_sel;
   logic [NOUT-1:0] sel_oh;
   logic [NOUT-1:0] load_oh;
   logic            in_range;
   logic            xfer;

   // One-hot decode of the effective select; an all-zero vector means the
   // select is out of range, which doubles as the range check.
   always_comb begin
      eff_sel = (state == S_PKT) ? cur_sel : in_sel;
      sel_oh  = '0;
      for (int k = 0; k < NOUT; k++) begin
         if (eff_sel == SELW'(k)) sel_oh[k] = 1'b1;
      end
      in_range = |sel_oh;
      // Out-of-range beats are always accepted so the source never stalls.
      in_ready = in_range ? |(sel_oh & (~out_valid | out_ready)) : 1'b1;
      xfer     = in_valid && in_ready;
      load_oh  = xfer ? sel_oh : '0;
   end

   assign busy = (state == S_PKT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cur_sel <= '0;
      end else if (xfer) begin
         case (state)
            S_IDLE: begin
               if (!in_last) begin
                  state   <= S_PKT;
                  cur_sel <= in_sel;
               end
            end
            default: begin
               if (in_last) state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (xfer && !in_range && (drop_cnt != 16'hFFFF)) begin
         drop_cnt <= drop_cnt + 16'd1;
      end
   end

   // A load wins over a drain on the same channel: the new beat replaces
   // the one being consumed and the channel stays valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_last  <= '0;
         out_data  <= '0;
      end else begin
         for (int k = 0; k < NOUT; k++) begin
            if (load_oh[k]) begin
               out_valid[k]                <= 1'b1;
               out_last[k]                 <= in_last;
               out_data[k*WIDTH +: WIDTH]  <= in_data;
            end else if (out_ready[k]) begin
               out_valid[k] <= 1'b0;
            end
         end
      end
   end

endmodule
